pixel_write_arbiter: RTL and testbench
======================================

# pixel_write_arbiter

Parametrised N-channel successor to the game's drawing state machine. Once per frame tick it sequences all sprite drawers (player, alien group, laser, …), arbitrates their per-pixel write requests over valid/ready handshakes, and issues a single registered write (linear address plus colour index) to port B of the display RAM. It sits between the drawer modules and `display_ram`.

## Interface
- `NUM_CH`, 4: number of drawer channels (2..8).
- `X_W`, 10: x coordinate width.
- `Y_W`, 9: y coordinate width.
- `COLOR_W`, 4: colour index width.
- `SCREEN_WIDTH`, 640: pixels per row; used as the address multiplier and the clip bound.
- `SCREEN_HEIGHT`, 480: number of rows; clip bound.
- `ADDR_W`, 19: width of the linear write address.
- `RR_MODE`, 1: 1 selects round-robin arbitration; 0 selects fixed priority (lowest index wins).
- Clock and reset: one clock; reset is synchronous and active-high.

Ports:
- `clock`  in  1  system clock (CLOCK_50).
- `global_reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  frame-tick pulse; starts a drawing pass.
- `ch_valid`  in  NUM_CH  per-channel pixel request.
- `ch_x`  in  NUM_CH*X_W  packed x coordinates; channel i occupies bits [i*X_W +: X_W].
- `ch_y`  in  NUM_CH*Y_W  packed y coordinates.
- `ch_color`  in  NUM_CH*COLOR_W  packed colour indices.
- `ch_done`  in  NUM_CH  level; drawer has finished its pass.
- `ch_ready`  out  NUM_CH  one-hot grant; combinational.
- `ch_reset`  out  NUM_CH  one-cycle drawer restart pulse.
- `wr_en`  out  1  framebuffer write strobe.
- `wr_addr`  out  ADDR_W  equals SCREEN_WIDTH*y + x.
- `wr_data`  out  COLOR_W  colour index.
- `busy`  out  1  high whenever state is not IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of a pass.
- `overrun`  out  1  sticky; set when `enable` arrives while `busy`.

## Operation
- States: IDLE, START, SETTLE, RUN.
- IDLE: on `enable`, go to START.
- START: assert all `ch_reset` bits for exactly one cycle, then go to SETTLE.
- SETTLE: one cycle with no grants, so drawers can deassert `ch_done`. Then go to RUN.
- RUN, eligibility: channel i is eligible when `ch_valid[i] & ~ch_done[i]`. A done channel is masked even if its valid is high.
- RUN, grant: `ch_ready` is one-hot over eligible channels and all-zero if none are eligible. A transfer occurs when valid and ready are both high.
- RUN, exit: when `&ch_done` is high, go to IDLE and pulse `frame_done` for one cycle. Any transfer accepted in that same cycle still writes.
- Fixed priority (RR_MODE=0): the lowest eligible index wins.
- Round-robin (RR_MODE=1): search starts at pointer `ptr`. After a transfer by channel g, `ptr` becomes (g+1) mod NUM_CH. `ptr` holds when no transfer occurs.
- `enable` while not IDLE is ignored for sequencing and sets `overrun`. Only `global_reset` clears `overrun`.
- Address arithmetic: computed at ADDR_W width; the result is truncated modulo 2^ADDR_W.
- `global_reset`, at any time including mid-RUN: state goes to IDLE and `ptr` to 0. The following outputs are 0: `wr_en`, `wr_addr`, `wr_data`, `ch_reset`, `frame_done`, `overrun`, `busy`. `ch_ready` is 0 because the state is IDLE.

## Timing
- A transfer accepted in cycle n produces `wr_en`, `wr_addr` and `wr_data` registered in cycle n+1.
- `wr_en` is low in every cycle not following an accepted transfer.
- `enable` sampled in cycle n → `ch_reset` high in cycle n+1 → SETTLE in n+2 → first possible grant in n+3.
- `frame_done` is high in the cycle after the one where `&ch_done` is seen in RUN; `busy` is low in that same cycle.
- No backpressure from the RAM side, so throughput is one pixel per cycle.

## Configuration
- `PIXEL_ARB_CLIP_EN` defined:
  - A transfer with x ≥ SCREEN_WIDTH or y ≥ SCREEN_HEIGHT is still accepted (`ch_ready` high, pointer advances), but `wr_en` stays 0.
  - Each such drop increments the `clip_count` output (8 bits, saturating at 255, cleared by reset).
- `PIXEL_ARB_CLIP_EN` undefined:
  - No clipping; the address wraps as per the arithmetic rule.
  - No `clip_count` port.

## Structure
- Package `pixel_arb_pkg` holds:
  - the state enum (IDLE, START, SETTLE, RUN);
  - the arbitration-mode constants (ARB_FIXED=0, ARB_RR=1);
  - the default screen and width constants shared with the drawer modules.
- Sub-module `pixel_arb_picker`: combinational one-hot picker taking the eligible vector, `ptr` and mode, returning the grant and grant index. It is instantiated once.

## Test plan
- Fixed priority, NUM_CH=4: all four channels valid with done=0 → grants go 0,0,0…; raise `ch_done[0]` → grants switch to channel 1.
- Round-robin: all valid continuously → grants 0,1,2,3,0 on consecutive RUN cycles; `wr_addr` for x=5, y=2 is 1285, one cycle after the grant.
- Sequencing: `enable` in cycle 10 → `ch_reset`=4'hF in cycle 11 → first grant in cycle 13; set all `ch_done` in cycle 20 → `frame_done` in cycle 21 and `busy`=0.
- Overrun: `enable` pulsed again during RUN → `overrun`=1 and no extra `ch_reset`; `global_reset` → `overrun`=0.
- Reset mid-RUN: assert `global_reset` while channel 2 is granted → next cycle state IDLE, `ch_ready`=0, `wr_en`=0, `ptr`=0.
- Clip (macro defined): x=640, y=0 accepted → `wr_en`=0 and `clip_count`=1; 300 such drops → `clip_count`=255.

Source files
------------

// File: rtl/pixel_arb_pkg.sv
// Shared types and constants for the pixel write arbiter and the sprite drawers.
package pixel_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        SETTLE = 2'd2,
        RUN    = 2'd3
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int DEFAULT_SCREEN_WIDTH  = 640;
    localparam int DEFAULT_SCREEN_HEIGHT = 480;
    localparam int DEFAULT_X_W           = 10;
    localparam int DEFAULT_Y_W           = 9;
    localparam int DEFAULT_COLOR_W       = 4;
    localparam int DEFAULT_ADDR_W        = 19;

endpackage

// File: rtl/pixel_arb_picker.sv
// Combinational one-hot picker: fixed priority from index 0, or round-robin from ptr.
module pixel_arb_picker #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [IDX_W-1:0]  ptr,
    input  logic              rr_mode,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              found
);

    always_comb begin
        int unsigned idx;
        logic [IDX_W-1:0] idx_l;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        idx_l     = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx   = rr_mode ? ((32'(ptr) + k) % NUM_CH) : k;
            idx_l = IDX_W'(idx);
            if (!found && eligible[idx_l]) begin
                found        = 1'b1;
                grant[idx_l] = 1'b1;
                grant_idx    = idx_l;
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Per-frame drawer sequencer and pixel write arbiter feeding display RAM port B.
// Optional clipping with clip_count port: define PIXEL_ARB_CLIP_EN.
module pixel_write_arbiter
    import pixel_arb_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int X_W           = DEFAULT_X_W,
    parameter int Y_W           = DEFAULT_Y_W,
    parameter int COLOR_W       = DEFAULT_COLOR_W,
    parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
    parameter int ADDR_W        = DEFAULT_ADDR_W,
    parameter int RR_MODE       = ARB_RR
) (
    input  logic                      clock,
    input  logic                      global_reset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         ch_valid,
    input  logic [NUM_CH*X_W-1:0]     ch_x,
    input  logic [NUM_CH*Y_W-1:0]     ch_y,
    input  logic [NUM_CH*COLOR_W-1:0] ch_color,
    input  logic [NUM_CH-1:0]         ch_done,
    output logic [NUM_CH-1:0]         ch_ready,
    output logic [NUM_CH-1:0]         ch_reset,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [COLOR_W-1:0]        wr_data,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      overrun
`ifdef PIXEL_ARB_CLIP_EN
    ,
    output logic [7:0]                clip_count
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_CH);
    localparam logic        RR    = (RR_MODE == ARB_RR);

    if (NUM_CH < 2 || NUM_CH > 8 || SCREEN_WIDTH < 1 || SCREEN_HEIGHT < 1) begin : g_param_check
        $error("pixel_write_arbiter: parameter out of range");
    end

    arb_state_t        state;
    logic [IDX_W-1:0]  ptr;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              found;
    logic              xfer;
    logic [X_W-1:0]    sel_x;
    logic [Y_W-1:0]    sel_y;
    logic [COLOR_W-1:0] sel_color;
    logic [ADDR_W-1:0] addr;
    logic              clipped;

    assign eligible = ch_valid & ~ch_done;

    pixel_arb_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .eligible  (eligible),
        .ptr       (ptr),
        .rr_mode   (RR),
        .grant     (grant),
        .grant_idx (grant_idx),
        .found     (found)
    );

    assign ch_ready = (state == RUN) ? grant : '0;
    assign xfer     = (state == RUN) && found;
    assign busy     = (state != IDLE);

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (grant[k]) begin
                sel_x     = ch_x[k*X_W +: X_W];
                sel_y     = ch_y[k*Y_W +: Y_W];
                sel_color = ch_color[k*COLOR_W +: COLOR_W];
            end
        end
        addr    = ADDR_W'(SCREEN_WIDTH) * ADDR_W'(sel_y) + ADDR_W'(sel_x);
        clipped = (32'(sel_x) >= 32'(SCREEN_WIDTH)) || (32'(sel_y) >= 32'(SCREEN_HEIGHT));
    end

    always_ff @(posedge clock) begin
        if (global_reset) begin
            state      <= IDLE;
            ptr        <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            ch_reset   <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
`ifdef PIXEL_ARB_CLIP_EN
            clip_count <= '0;
`endif
        end else begin
            ch_reset   <= '0;
            frame_done <= 1'b0;
            wr_en      <= 1'b0;

            if (enable && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= START;
                        ch_reset <= '1;
                    end
                end
                START:  state <= SETTLE;
                SETTLE: state <= RUN;
                RUN: begin
                    if (&ch_done) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Out-of-screen pixels are still handshaken so the drawer never stalls.
            if (xfer) begin
                wr_addr <= addr;
                wr_data <= sel_color;
`ifdef PIXEL_ARB_CLIP_EN
                if (clipped) begin
                    if (clip_count != 8'hFF)
                        clip_count <= clip_count + 8'd1;
                end else begin
                    wr_en <= 1'b1;
                end
`else
                wr_en <= 1'b1;
`endif
                if (RR)
                    ptr <= (grant_idx == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

`ifndef PIXEL_ARB_CLIP_EN
    logic unused_clip;
    assign unused_clip = clipped;
`endif

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share one stimulus stream.
module tb_pixel_write_arbiter;

    localparam int NUM_CH  = 4;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 4;
    localparam int ADDR_W  = 19;

    logic                      clock = 1'b0;
    logic                      global_reset;
    logic                      enable;
    logic [NUM_CH-1:0]         ch_valid;
    logic [NUM_CH*X_W-1:0]     ch_x;
    logic [NUM_CH*Y_W-1:0]     ch_y;
    logic [NUM_CH*COLOR_W-1:0] ch_color;
    logic [NUM_CH-1:0]         ch_done;

    logic [NUM_CH-1:0]  rr_ready, rr_reset, fp_ready, fp_reset;
    logic               rr_wr_en, fp_wr_en, rr_busy, fp_busy;
    logic               rr_frame_done, fp_frame_done, rr_overrun, fp_overrun;
    logic [ADDR_W-1:0]  rr_wr_addr, fp_wr_addr;
    logic [COLOR_W-1:0] rr_wr_data, fp_wr_data;
`ifdef PIXEL_ARB_CLIP_EN
    logic [7:0]         rr_clip_count, fp_clip_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pixel_write_arbiter #(
        .NUM_CH(NUM_CH), .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W),
        .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .ADDR_W(ADDR_W), .RR_MODE(1)
    ) dut_rr (
        .clock(clock), .global_reset(global_reset), .enable(enable),
        .ch_valid(ch_valid), .ch_x(ch_x), .ch_y(ch_y), .ch_color(ch_color),
        .ch_done(ch_done), .ch_ready(rr_ready), .ch_reset(rr_reset),
        .wr_en(rr_wr_en), .wr_addr(rr_wr_addr), .wr_data(rr_wr_data),
        .busy(rr_busy), .frame_done(rr_frame_done), .overrun(rr_overrun)
`ifdef PIXEL_ARB_CLIP_EN
        , .clip_count(rr_clip_count)
`endif
    );

    pixel_write_arbiter #(
        .NUM_CH(NUM_CH), .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W),
        .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .ADDR_W(ADDR_W), .RR_MODE(0)
    ) dut_fp (
        .clock(clock), .global_reset(global_reset), .enable(enable),
        .ch_valid(ch_valid), .ch_x(ch_x), .ch_y(ch_y), .ch_color(ch_color),
        .ch_done(ch_done), .ch_ready(fp_ready), .ch_reset(fp_reset),
        .wr_en(fp_wr_en), .wr_addr(fp_wr_addr), .wr_data(fp_wr_data),
        .busy(fp_busy), .frame_done(fp_frame_done), .overrun(fp_overrun)
`ifdef PIXEL_ARB_CLIP_EN
        , .clip_count(fp_clip_count)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_pass();
        ch_done = '1;
        enable  = 1'b1;
        tick();
        enable  = 1'b0;
        ch_done = '0;
        tick();
        tick();
        #1;
    endtask

    task automatic test_reset();
        global_reset = 1'b1;
        tick();
        tick();
        n_checks++; if (rr_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", rr_wr_en); end
        n_checks++; if (rr_wr_addr !== 19'd0) begin n_fail++; $display("FAIL reset_wr_addr got %0d want 0", rr_wr_addr); end
        n_checks++; if (rr_ready !== 4'h0 || fp_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready got %h/%h want 0", rr_ready, fp_ready); end
        n_checks++; if (rr_reset !== 4'h0) begin n_fail++; $display("FAIL reset_ch_reset got %h want 0", rr_reset); end
        n_checks++; if (rr_busy !== 1'b0 || rr_overrun !== 1'b0 || rr_frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got busy=%b ovr=%b fd=%b want 0", rr_busy, rr_overrun, rr_frame_done); end
        global_reset = 1'b0;
        tick();
    endtask

    // Sequencing plus round-robin vs fixed-priority grant order in one pass.
    task automatic test_sequencing_and_arbitration();
        ch_x     = {10'd639, 10'd0, 10'd10, 10'd5};
        ch_y     = {9'd479, 9'd1, 9'd0, 9'd2};
        ch_color = {4'd4, 4'd3, 4'd2, 4'd1};
        ch_valid = '0;
        ch_done  = '1;
        enable   = 1'b1;
        tick();
        n_checks++; if (rr_reset !== 4'hF) begin n_fail++; $display("FAIL start_ch_reset got %h want f", rr_reset); end
        n_checks++; if (rr_busy !== 1'b1) begin n_fail++; $display("FAIL start_busy got %b want 1", rr_busy); end
        enable   = 1'b0;
        ch_done  = '0;
        ch_valid = '1;
        tick();
        #1;
        n_checks++; if (rr_reset !== 4'h0) begin n_fail++; $display("FAIL settle_ch_reset got %h want 0", rr_reset); end
        n_checks++; if (rr_ready !== 4'h0) begin n_fail++; $display("FAIL settle_ready got %h want 0", rr_ready); end
        tick();
        n_checks++; if (rr_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_grant0 got %b want 0001", rr_ready); end
        n_checks++; if (fp_ready !== 4'b0001) begin n_fail++; $display("FAIL fp_grant0 got %b want 0001", fp_ready); end
        n_checks++; if (rr_wr_en !== 1'b0) begin n_fail++; $display("FAIL first_run_wr_en got %b want 0", rr_wr_en); end
        tick();
        n_checks++; if (rr_ready !== 4'b0010) begin n_fail++; $display("FAIL rr_grant1 got %b want 0010", rr_ready); end
        n_checks++; if (rr_wr_en !== 1'b1 || rr_wr_addr !== 19'd1285 || rr_wr_data !== 4'd1) begin
            n_fail++; $display("FAIL rr_write0 got en=%b addr=%0d data=%0d want 1/1285/1", rr_wr_en, rr_wr_addr, rr_wr_data); end
        n_checks++; if (fp_ready !== 4'b0001 || fp_wr_addr !== 19'd1285) begin
            n_fail++; $display("FAIL fp_hold0 got ready=%b addr=%0d want 0001/1285", fp_ready, fp_wr_addr); end
        tick();
        n_checks++; if (rr_ready !== 4'b0100) begin n_fail++; $display("FAIL rr_grant2 got %b want 0100", rr_ready); end
        n_checks++; if (rr_wr_addr !== 19'd10 || rr_wr_data !== 4'd2) begin
            n_fail++; $display("FAIL rr_write1 got addr=%0d data=%0d want 10/2", rr_wr_addr, rr_wr_data); end
        tick();
        n_checks++; if (rr_ready !== 4'b1000) begin n_fail++; $display("FAIL rr_grant3 got %b want 1000", rr_ready); end
        n_checks++; if (rr_wr_addr !== 19'd640 || rr_wr_data !== 4'd3) begin
            n_fail++; $display("FAIL rr_write2 got addr=%0d data=%0d want 640/3", rr_wr_addr, rr_wr_data); end
        tick();
        n_checks++; if (rr_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_wrap got %b want 0001", rr_ready); end
        n_checks++; if (rr_wr_addr !== 19'd307199 || rr_wr_data !== 4'd4) begin
            n_fail++; $display("FAIL rr_write3 got addr=%0d data=%0d want 307199/4", rr_wr_addr, rr_wr_data); end
        ch_done = 4'b0001;
        #1;
        n_checks++; if (fp_ready !== 4'b0010) begin n_fail++; $display("FAIL fp_done_mask got %b want 0010", fp_ready); end
        n_checks++; if (rr_ready !== 4'b0010) begin n_fail++; $display("FAIL rr_done_mask got %b want 0010", rr_ready); end
        tick();
        n_checks++; if (fp_wr_addr !== 19'd10 || rr_wr_addr !== 19'd10) begin
            n_fail++; $display("FAIL masked_write got %0d/%0d want 10", rr_wr_addr, fp_wr_addr); end
        n_checks++; if (rr_ready !== 4'b0100 || fp_ready !== 4'b0010) begin
            n_fail++; $display("FAIL after_mask got rr=%b fp=%b want 0100/0010", rr_ready, fp_ready); end
        enable = 1'b1;
        tick();
        enable = 1'b0;
        n_checks++; if (rr_overrun !== 1'b1 || rr_reset !== 4'h0 || rr_busy !== 1'b1) begin
            n_fail++; $display("FAIL overrun got ovr=%b ch_reset=%h busy=%b want 1/0/1", rr_overrun, rr_reset, rr_busy); end
        ch_done = '1;
        #1;
        n_checks++; if (rr_ready !== 4'h0) begin n_fail++; $display("FAIL all_done_ready got %b want 0", rr_ready); end
        tick();
        n_checks++; if (rr_frame_done !== 1'b1 || rr_busy !== 1'b0 || rr_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL frame_done got fd=%b busy=%b wr_en=%b want 1/0/0", rr_frame_done, rr_busy, rr_wr_en); end
        tick();
        n_checks++; if (rr_frame_done !== 1'b0 || rr_overrun !== 1'b1) begin
            n_fail++; $display("FAIL frame_done_pulse got fd=%b ovr=%b want 0/1", rr_frame_done, rr_overrun); end
        global_reset = 1'b1;
        tick();
        global_reset = 1'b0;
        n_checks++; if (rr_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got %b want 0", rr_overrun); end
        tick();
    endtask

    // Pointer holds across an idle cycle; reset mid-RUN returns ptr to 0.
    task automatic test_hold_and_reset_mid_run();
        ch_valid = '1;
        begin_pass();
        n_checks++; if (rr_ready !== 4'b0001) begin n_fail++; $display("FAIL pass2_grant0 got %b want 0001", rr_ready); end
        tick();
        ch_valid = '0;
        #1;
        n_checks++; if (rr_ready !== 4'h0) begin n_fail++; $display("FAIL no_valid_ready got %b want 0", rr_ready); end
        tick();
        n_checks++; if (rr_wr_en !== 1'b0) begin n_fail++; $display("FAIL idle_wr_en got %b want 0", rr_wr_en); end
        ch_valid = '1;
        #1;
        n_checks++; if (rr_ready !== 4'b0010) begin n_fail++; $display("FAIL ptr_hold got %b want 0010", rr_ready); end
        tick();
        n_checks++; if (rr_ready !== 4'b0100) begin n_fail++; $display("FAIL pre_reset_grant got %b want 0100", rr_ready); end
        global_reset = 1'b1;
        tick();
        n_checks++; if (rr_ready !== 4'h0 || rr_wr_en !== 1'b0 || rr_busy !== 1'b0 || rr_wr_addr !== 19'd0) begin
            n_fail++; $display("FAIL mid_reset got ready=%b en=%b busy=%b addr=%0d want 0", rr_ready, rr_wr_en, rr_busy, rr_wr_addr); end
        global_reset = 1'b0;
        tick();
        begin_pass();
        n_checks++; if (rr_ready !== 4'b0001) begin n_fail++; $display("FAIL ptr_after_reset got %b want 0001", rr_ready); end
        ch_done = '1;
        tick();
        tick();
    endtask

`ifdef PIXEL_ARB_CLIP_EN
    task automatic test_clip();
        global_reset = 1'b1;
        tick();
        global_reset = 1'b0;
        ch_x     = {30'd0, 10'd640};
        ch_y     = '0;
        ch_valid = 4'b0001;
        begin_pass();
        n_checks++; if (rr_ready !== 4'b0001) begin n_fail++; $display("FAIL clip_ready got %b want 0001", rr_ready); end
        tick();
        n_checks++; if (rr_wr_en !== 1'b0 || rr_clip_count !== 8'd1) begin
            n_fail++; $display("FAIL clip_one got en=%b cnt=%0d want 0/1", rr_wr_en, rr_clip_count); end
        for (int unsigned i = 0; i < 299; i++) tick();
        n_checks++; if (rr_clip_count !== 8'd255) begin n_fail++; $display("FAIL clip_sat got %0d want 255", rr_clip_count); end
        ch_done = '1;
        tick();
        tick();
    endtask
`endif

    initial begin
        global_reset = 1'b1;
        enable   = 1'b0;
        ch_valid = '0;
        ch_x     = '0;
        ch_y     = '0;
        ch_color = '0;
        ch_done  = '1;
        test_reset();
        test_sequencing_and_arbitration();
        test_hold_and_reset_mid_run();
`ifdef PIXEL_ARB_CLIP_EN
        test_clip();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
